// File: rtl/pipeline_exec_controller.sv
// Command sequencer between the UART receiver and the pipeline: decodes command words,
// streams program words into instruction memory and gates pipeline execution via o_halt.
module pipeline_exec_controller #(
  parameter int DATA_BITS = 32,
  parameter int MAX_INST  = 256,
  parameter int ADDR_STEP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [DATA_BITS-1:0] i_cmd_data,
  input  logic                 i_program_end,
  output logic                 o_write_inst,
  output logic [31:0]          o_write_addr,
  output logic [DATA_BITS-1:0] o_write_data,
  output logic                 o_halt,
  output logic [2:0]           o_state,
  output logic [31:0]          o_cycle_count,
  output logic                 o_cmd_error,
  output logic                 o_done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] STEP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_STEP  = 8'h03;
  localparam logic [7:0] OP_HALT  = 8'h04;
  localparam logic [7:0] OP_CLEAR = 8'h05;

  localparam logic [15:0] MAX_N   = 16'(MAX_INST);
  localparam logic [31:0] STEP_SZ = 32'(ADDR_STEP);

  logic [2:0]           state_q, state_d;
  logic                 halt_q, halt_d;
  logic                 writeInst_q, writeInst_d;
  logic [31:0]          writeAddr_q, writeAddr_d;
  logic [DATA_BITS-1:0] writeData_q, writeData_d;
  logic [31:0]          cycleCount_q, cycleCount_d;
  logic                 cmdError_q, cmdError_d;
  logic                 done_q, done_d;
  logic [15:0]          wordCnt_q, wordCnt_d;
  logic [15:0]          loadLen_q, loadLen_d;
  logic                 clearCount;

  logic [7:0]  opcode;
  logic [15:0] arg;

  assign opcode = i_cmd_data[DATA_BITS-1 -: 8];
  assign arg    = i_cmd_data[15:0];

  // Program end outranks any command arriving in the same cycle while executing.
  always_comb begin
    state_d     = state_q;
    writeInst_d = 1'b0;
    writeAddr_d = writeAddr_q;
    writeData_d = writeData_q;
    cmdError_d  = 1'b0;
    done_d      = 1'b0;
    wordCnt_d   = wordCnt_q;
    loadLen_d   = loadLen_q;
    clearCount  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_cmd_valid) begin
          case (opcode)
            OP_LOAD: begin
              if (arg != 16'd0 && arg <= MAX_N) begin
                state_d    = LOAD;
                loadLen_d  = arg;
                wordCnt_d  = 16'd0;
                clearCount = 1'b1;
              end else begin
                cmdError_d = 1'b1;
              end
            end
            OP_RUN: begin
              if (state_q == DONE) cmdError_d = 1'b1;
              else                 state_d    = RUN;
            end
            OP_STEP: begin
              if (state_q == DONE) cmdError_d = 1'b1;
              else                 state_d    = STEP;
            end
            OP_HALT: state_d = IDLE;
            OP_CLEAR: begin
              state_d    = IDLE;
              wordCnt_d  = 16'd0;
              clearCount = 1'b1;
            end
            default: cmdError_d = 1'b1;
          endcase
        end
      end
      LOAD: begin
        if (i_cmd_valid) begin
          writeInst_d = 1'b1;
          writeAddr_d = 32'(wordCnt_q) * STEP_SZ;
          writeData_d = i_cmd_data;
          wordCnt_d   = wordCnt_q + 16'd1;
          if (wordCnt_q == loadLen_q - 16'd1) state_d = IDLE;
        end
      end
      RUN: begin
        if (i_program_end) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (i_cmd_valid) begin
          case (opcode)
            OP_HALT: state_d = IDLE;
            OP_CLEAR: begin
              state_d    = IDLE;
              wordCnt_d  = 16'd0;
              clearCount = 1'b1;
            end
            default: cmdError_d = 1'b1;
          endcase
        end
      end
      STEP: begin
        if (i_program_end) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
          if (i_cmd_valid) begin
            case (opcode)
              OP_HALT: ;
              OP_CLEAR: begin
                wordCnt_d  = 16'd0;
                clearCount = 1'b1;
              end
              default: cmdError_d = 1'b1;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase

    halt_d = !(state_d == RUN || state_d == STEP);

    // Count the cycle just finished if the pipeline advanced in it; saturate at all-ones.
    cycleCount_d = cycleCount_q;
    if (clearCount)
      cycleCount_d = 32'd0;
    else if (!halt_q && cycleCount_q != 32'hFFFF_FFFF)
      cycleCount_d = cycleCount_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      halt_q       <= 1'b1;
      writeInst_q  <= 1'b0;
      writeAddr_q  <= 32'd0;
      writeData_q  <= '0;
      cycleCount_q <= 32'd0;
      cmdError_q   <= 1'b0;
      done_q       <= 1'b0;
      wordCnt_q    <= 16'd0;
      loadLen_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      halt_q       <= halt_d;
      writeInst_q  <= writeInst_d;
      writeAddr_q  <= writeAddr_d;
      writeData_q  <= writeData_d;
      cycleCount_q <= cycleCount_d;
      cmdError_q   <= cmdError_d;
      done_q       <= done_d;
      wordCnt_q    <= wordCnt_d;
      loadLen_q    <= loadLen_d;
    end
  end

  assign o_state       = state_q;
  assign o_halt        = halt_q;
  assign o_write_inst  = writeInst_q;
  assign o_write_addr  = writeAddr_q;
  assign o_write_data  = writeData_q;
  assign o_cycle_count = cycleCount_q;
  assign o_cmd_error   = cmdError_q;
  assign o_done        = done_q;

endmodule
